reg_dump: RTL and testbench

Debug register-file reader for the OTTER MCU. On a start pulse it walks all 32 architectural registers through a dedicated asynchronous read port of the register file. It streams each register out as bytes over a valid/ready byte interface, headed by a sync byte. The byte stream feeds the debug UART transmitter; the block never writes the register file.

---
 rtl/otter_dbg_pkg.sv | 19 +
 rtl/reg_dump.sv | 117 +++++++++++
 tb/tb_reg_dump.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/otter_dbg_pkg.sv
// Shared debug definitions for the OTTER register dump path and debug UART.
// Holds the dump FSM state type, frame header byte and default geometry.
package otter_dbg_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;

    localparam logic [7:0] DUMP_HDR = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LOAD,
        ST_SEND,
        ST_FIN
    } dump_state_e;

endpackage

// File: rtl/reg_dump.sv
// Walks every architectural register through a spare async read port and streams a
// 0xA5-headed, LSB-first byte frame over valid/ready; stalls hold TX data stable.
module reg_dump
    import otter_dbg_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic [ADDR_W-1:0] o_rf_addr,
    input  logic [DATA_W-1:0] i_rf_data,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic              o_busy,
    output logic              o_done
);

    localparam int BYTES = DATA_W / 8;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    dump_state_e       r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_index, w_index_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic [BC_W-1:0]   r_byte,  w_byte_nxt;
    logic [7:0]        r_tx_data, w_tx_data_nxt;
    logic              r_tx_valid, r_busy, r_done;
    logic              w_xfer;

    assign w_xfer = r_tx_valid && i_tx_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_index    <= '0;
            r_shift    <= '0;
            r_byte     <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_index    <= w_index_nxt;
            r_shift    <= w_shift_nxt;
            r_byte     <= w_byte_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= (w_state_nxt == ST_HDR) || (w_state_nxt == ST_SEND);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= (w_state_nxt == ST_FIN);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_index_nxt   = r_index;
        w_shift_nxt   = r_shift;
        w_byte_nxt    = r_byte;
        w_tx_data_nxt = r_tx_data;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_HDR;
                    w_index_nxt = '0;
                end
            end
            ST_HDR: begin
                if (w_xfer) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_shift_nxt = i_rf_data;
                w_byte_nxt  = '0;
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (w_xfer) begin
                    w_shift_nxt = r_shift >> 8;
                    if (r_byte == LAST_BYTE) begin
                        if (r_index == LAST_IDX) begin
                            w_state_nxt = ST_FIN;
                        end else begin
                            w_index_nxt = r_index + 1'b1;
                            w_state_nxt = ST_LOAD;
                        end
                    end else begin
                        w_byte_nxt = r_byte + 1'b1;
                    end
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Output byte is registered, so it is chosen from the state being entered.
        if (w_state_nxt == ST_HDR)
            w_tx_data_nxt = DUMP_HDR;
        else if (w_state_nxt == ST_SEND)
            w_tx_data_nxt = w_shift_nxt[7:0];
    end

    assign o_rf_addr  = r_index;
    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: byte frame content/timing, backpressure, START
// filtering, mid-frame reset and per-register snapshot behaviour.
module tb_reg_dump;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    logic [31:0] rf [0:31];
    assign rf_data = rf[rf_addr];

    reg_dump dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .o_rf_addr  (rf_addr),
        .i_rf_data  (rf_data),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_busy     (busy),
        .o_done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every accepted byte, DONE pulses and stall-stability violations.
    logic [7:0] cap_q[$];
    int         cap_cyc[$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         stall_viol = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_viol++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (tx_valid && tx_ready) begin
                cap_q.push_back(tx_data);
                cap_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         pos;
        logic [7:0] val;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] frame[$];
    int         fcyc[$];
    logic [7:0] golden[$];
    int         t0, base_b, base_d, base_s;

    function automatic int exp_cycle(input int pos);
        if (pos == 0) return 1;
        return 3 + 5 * ((pos - 1) / 4) + ((pos - 1) % 4);
    endfunction

    function automatic logic [7:0] model_byte(input int pos);
        logic [31:0] v;
        int          r;
        if (pos == 0) return 8'hA5;
        r = (pos - 1) / 4;
        if (r == 1)       v = 32'h12345678;
        else if (r == 31) v = 32'hDEADBEEF;
        else              v = r * 32'h01010101;
        return v[8*((pos-1)%4) +: 8];
    endfunction

    function automatic int diff_golden();
        int n = 0;
        if (frame.size() != golden.size()) return 999;
        foreach (frame[i]) if (frame[i] !== golden[i]) n++;
        return n;
    endfunction

    task automatic rf_init();
        for (int i = 0; i < 32; i++) rf[i] = i * 32'h01010101;
        rf[1]  = 32'h12345678;
        rf[31] = 32'hDEADBEEF;
    endtask

    // Caller sits 1ns after a rising edge; returns 1ns after the edge that follows DONE.
    task automatic run_frame(input int low_pct, input bit mid_start, input bit mod5);
        int  rc;
        bit  seen = 0;
        base_b = cap_q.size();
        base_d = done_cnt;
        base_s = stall_viol;
        t0 = cyc;
        start = 1'b1;
        tx_ready = ($urandom_range(0, 99) >= low_pct);
        for (int c = 0; c < 1500 && !seen; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                check("busy_at_done", busy, 1'b1);
            end
            @(posedge clk);
            #1;
            rc = cyc - t0;
            start = mid_start && (rc == 30 || rc == 31 || rc == 90);
            tx_ready = ($urandom_range(0, 99) >= low_pct);
            if (mod5 && rc == 24) rf[5] = 32'hCAFEF00D;
            if (mod5 && rc == 29) rf[5] = 32'h11111111;
        end
        start = 1'b0;
        if (!seen) check("frame_timeout", 0, 1);
        frame = cap_q[base_b:$];
        fcyc  = cap_cyc[base_b:$];
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        tx_ready = 1'b1;
        rf_init();

        // Reset held, START toggling
        for (int i = 0; i < 4; i++) begin
            start = i[0];
            @(negedge clk);
            check("reset_outputs", {tx_valid, busy, done, rf_addr, tx_data}, 64'd0);
        end
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        base_b = cap_q.size();
        repeat (10) @(posedge clk);
        #1;
        check("idle_no_bytes", cap_q.size() - base_b, 0);
        check("idle_busy", {busy, tx_valid}, 2'b00);

        // Full dump, sink always ready
        vecs = '{'{0, 8'hA5}, '{1, 8'h00}, '{2, 8'h00}, '{3, 8'h00}, '{4, 8'h00},
                 '{5, 8'h78}, '{6, 8'h56}, '{7, 8'h34}, '{8, 8'h12}, '{9, 8'h02},
                 '{12, 8'h02}, '{121, 8'h1E}, '{125, 8'hEF}, '{126, 8'hBE},
                 '{127, 8'hAD}, '{128, 8'hDE}};
        run_frame(0, 0, 0);
        check("ready_byte_count", frame.size(), 129);
        if (frame.size() == 129) begin
            foreach (vecs[i]) begin
                check($sformatf("byte%0d", vecs[i].pos), frame[vecs[i].pos], vecs[i].val);
                check($sformatf("cycle_of_byte%0d", vecs[i].pos),
                      fcyc[vecs[i].pos] - t0, exp_cycle(vecs[i].pos));
            end
            begin
                int n = 0;
                for (int p = 0; p < 129; p++) if (frame[p] !== model_byte(p)) n++;
                check("ready_frame_vs_model", n, 0);
            end
        end
        check("ready_done_count", done_cnt - base_d, 1);
        check("ready_done_cycle", done_cyc - t0, 162);
        check("busy_low_cycle163", busy, 1'b0);
        golden = frame;

        // Random backpressure
        run_frame(40, 0, 0);
        check("bp_frame_vs_ready", diff_golden(), 0);
        check("bp_stall_stable", stall_viol - base_s, 0);
        check("bp_done_count", done_cnt - base_d, 1);

        // START while busy, then back-to-back START in cycle 163
        run_frame(0, 1, 0);
        check("midstart_frame", diff_golden(), 0);
        check("midstart_done_count", done_cnt - base_d, 1);
        run_frame(0, 0, 0);
        check("b2b_first_byte", frame.size() > 0 ? frame[0] : 8'hxx, 8'hA5);
        check("b2b_first_cycle", fcyc.size() > 0 ? fcyc[0] - t0 : -1, 1);
        check("b2b_frame", diff_golden(), 0);

        // Reset after the 50th byte
        base_b = cap_q.size();
        base_d = done_cnt;
        start = 1'b1;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 400 && cap_q.size() - base_b < 50; c++) begin
            @(negedge clk); #1;
        end
        check("reached_byte50", cap_q.size() - base_b, 50);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {tx_valid, busy, done, rf_addr, tx_data}, 64'd0);
        repeat (3) @(negedge clk);
        check("reset_no_done", done_cnt - base_d, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        base_b = cap_q.size();
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_idle", {cap_q.size() - base_b, busy}, 0);
        run_frame(0, 0, 0);
        check("post_reset_frame", diff_golden(), 0);

        // x5 rewritten between x4 LOAD and x5 LOAD, then again during x5 SEND
        run_frame(0, 0, 1);
        rf[5] = 32'h05050505;
        if (frame.size() == 129) begin
            check("x5_snapshot", {frame[24], frame[23], frame[22], frame[21]}, 32'hCAFEF00D);
            check("x6_after_mod", frame[25], 8'h06);
        end else begin
            check("mod_frame_size", frame.size(), 129);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
